// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path defaults and the buffered {instruction, pc} entry type
package mips_pkg;

    localparam int IFQ_ADDR_W   = 8;
    localparam int IFQ_DATA_W   = 32;
    localparam int IFQ_DEPTH    = 4;
    localparam int IFQ_RESET_PC = 0;

    typedef struct packed {
        logic [IFQ_DATA_W-1:0] data;
        logic [IFQ_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous prefetch FIFO with flush; flush wins over a same-cycle push
module ifq_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; consumers only see it through a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - credit-limited instruction fetch with prefetch FIFO and redirect squash
// Optional IFQ_BYPASS_EN: forward a response straight to the datapath when the FIFO is empty.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = IFQ_ADDR_W,
    parameter int                DATA_W   = IFQ_DATA_W,
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_W-1:0]          imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [DATA_W-1:0]          imem_rsp_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_W-1:0]          inst_data,
    output logic [ADDR_W-1:0]          inst_pc,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]     ifq_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [EW-1:0]     head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [CW:0]       credit_used;

    // Buffered entries and in-flight fetches share DEPTH credits, so a push never finds the FIFO full.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep = rsp_fire && (drop_q == '0) && !redirect_valid && !reset;

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty && inst_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push       = rsp_keep && !bypass;
    assign pop        = !reset && !fifo_empty && inst_ready;
    assign inst_valid = !reset && (!fifo_empty || bypass);
    assign inst_data  = !inst_valid ? '0 : (bypass ? imem_rsp_data : head[EW-1:ADDR_W]);
    assign inst_pc    = !inst_valid ? '0 : (bypass ? rsp_pc_q : head[ADDR_W-1:0]);
    assign ifq_count  = reset ? '0 : fifo_count;

    ifq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({imem_rsp_data, rsp_pc_q}),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = outstanding_q - CW'(rsp_fire);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 1'b1;
            if (rsp_fire) begin
                if (drop_q != '0) drop_d = drop_q - 1'b1;
                else              rsp_pc_d = rsp_pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule
